// File: rtl/avs_pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle registers and per-bit
// hardware blink driven by a programmable prescaler.
module avs_pio_out_blink #(
  parameter int unsigned       WIDTH          = 4,
  parameter int unsigned       PERIOD_W       = 24,
  parameter int unsigned       DEFAULT_PERIOD = 12499999,
  parameter logic [WIDTH-1:0]  RESET_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  typedef enum logic [2:0] {
    A_DATA   = 3'd0,
    A_BLINK  = 3'd1,
    A_PERIOD = 3'd2,
    A_STATUS = 3'd3,
    A_OUTSET = 3'd4,
    A_OUTCLR = 3'd5,
    A_OUTTGL = 3'd6,
    A_RSVD   = 3'd7
  } addr_e;

  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(DEFAULT_PERIOD);

  addr_e               addr;
  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic                unused_wd;

  logic [WIDTH-1:0]    data_q,   data_d;
  logic [WIDTH-1:0]    blink_q,  blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic                phase_q,  phase_d;
  logic [WIDTH-1:0]    out_q,    out_d;

  assign addr      = addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;

    // Prescaler; a PERIOD write below overrides the terminal-count toggle.
    if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
      phase_d = phase_q;
    end

    if (wr) begin
      case (addr)
        A_DATA:   data_d  = wd;
        A_BLINK:  blink_d = wd;
        A_PERIOD: begin
          period_d = writedata[PERIOD_W-1:0];
          cnt_d    = '0;
          phase_d  = 1'b1;
        end
        A_OUTSET: data_d = data_q | wd;
        A_OUTCLR: data_d = data_q & ~wd;
        A_OUTTGL: data_d = data_q ^ wd;
        default:  ;
      endcase
    end

    out_d = data_d & ~(blink_d & {WIDTH{~phase_d}});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= PERIOD_RST;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_q    <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (addr)
      A_DATA:   readdata[WIDTH-1:0]    = data_q;
      A_BLINK:  readdata[WIDTH-1:0]    = blink_q;
      A_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      A_STATUS: readdata[0]            = phase_q;
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avs_pio_out_blink.sv
// Bench for avs_pio_out_blink: constant vector table, hand-written blink
// sequences and a randomized run against a cycle-count based reference model.
module tb_avs_pio_out_blink;

  localparam int unsigned DEF_P = 12499999;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: registers plus edges elapsed since the prescaler restarted.
  logic [3:0]  m_data;
  logic [3:0]  m_blink;
  logic [23:0] m_period;
  int unsigned m_n;

  avs_pio_out_blink #(
    .WIDTH(4),
    .PERIOD_W(24),
    .DEFAULT_PERIOD(DEF_P),
    .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic m_phase();
    if (m_period == 24'd0) return 1'b1;
    return ((m_n / (m_period + 1)) % 2) == 0;
  endfunction

  function automatic logic [3:0] m_out();
    return m_data & ~(m_blink & (m_phase() ? 4'h0 : 4'hF));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_data};
      3'd1: return {28'd0, m_blink};
      3'd2: return {8'd0, m_period};
      3'd3: return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive, take the edge, advance the model, check against the model.
  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] d);
    int unsigned n_next;
    reset_n = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_data = 4'h0; m_blink = 4'h0; m_period = DEF_P[23:0]; m_n = 0;
    end else begin
      n_next = (m_period == 24'd0) ? 0 : m_n + 1;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = d[3:0];
          3'd1: m_blink = d[3:0];
          3'd2: begin m_period = d[23:0]; n_next = 0; end
          3'd4: m_data = m_data | d[3:0];
          3'd5: m_data = m_data & ~d[3:0];
          3'd6: m_data = m_data ^ d[3:0];
          default: ;
        endcase
      end
      m_n = n_next;
    end
    chk("model_out", {28'd0, out_port}, {28'd0, m_out()});
    chk("model_rd", readdata, m_read(a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic idle(input logic [2:0] a);
    step(1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic exp_out(input string name, input logic [3:0] v);
    chk(name, {28'd0, out_port}, {28'd0, v});
  endtask

  typedef struct {
    logic        rst_n;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [3:0]  eout;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    m_data = 4'h0; m_blink = 4'h0; m_period = DEF_P[23:0]; m_n = 0;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd2, 32'h0, 4'h0, DEF_P};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 4'h0, 32'h1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'hA, 4'hA, 32'hA};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h1, 4'hB, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd5, 32'h8, 4'h3, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd6, 32'h6, 4'h5, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 4'h5, 32'h5};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h5, 32'h1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd7, 32'hF, 4'h5, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 4'h5, 32'h5};

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst_n, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), {28'd0, out_port}, {28'd0, vecs[i].eout});
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].erd);
    end

    // Blink with PERIOD=3: phase flips every 4 edges after the PERIOD write.
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h1);
    wr(3'd0, 32'hF);          exp_out("blink_e2", 4'hF);
    idle(3'd3);               exp_out("blink_e3", 4'hF);
    idle(3'd3);               exp_out("blink_e4", 4'hE); chk("status_e4", readdata, 32'h0);
    idle(3'd3); idle(3'd3);
    idle(3'd3);               exp_out("blink_e7", 4'hE);
    idle(3'd3);               exp_out("blink_e8", 4'hF); chk("status_e8", readdata, 32'h1);
    idle(3'd3); idle(3'd3); idle(3'd3);
    // PERIOD write on the terminal-count edge suppresses the toggle.
    wr(3'd2, 32'd3);          exp_out("restart_e12", 4'hF);
    idle(3'd3); idle(3'd3);
    idle(3'd3);               exp_out("restart_e15", 4'hF);
    idle(3'd3);               exp_out("restart_e16", 4'hE); chk("status_e16", readdata, 32'h0);

    // PERIOD=0 freezes the on phase; PERIOD=1 toggles every 2 edges.
    wr(3'd2, 32'd0);          exp_out("frozen_w", 4'hF);
    for (int i = 0; i < 6; i++) begin
      idle(3'd3);             exp_out("frozen", 4'hF);
    end
    wr(3'd2, 32'd1);          exp_out("p1_e0", 4'hF);
    idle(3'd3);               exp_out("p1_e1", 4'hF);
    idle(3'd3);               exp_out("p1_e2", 4'hE);
    idle(3'd3);               exp_out("p1_e3", 4'hE);
    idle(3'd3);               exp_out("p1_e4", 4'hF);
    idle(3'd3);
    idle(3'd3);               exp_out("p1_e6", 4'hE);

    // Reset with a concurrent DATA write: write is lost.
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'h3);
    exp_out("rst_out", 4'h0); chk("rst_data", readdata, 32'h0);
    idle(3'd2);               chk("rst_period", readdata, DEF_P);
    idle(3'd3);               chk("rst_status", readdata, 32'h1);
    idle(3'd1);               chk("rst_blink", readdata, 32'h0);

    // Randomized traffic against the model; small periods so blinking is exercised.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      logic        rst, cs, wn;
      a   = 3'($urandom_range(0, 7));
      d   = $urandom;
      if (a == 3'd2) d = 32'($urandom_range(0, 5)) | (d & 32'hFF00_0000);
      rst = ($urandom_range(0, 59) != 0);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 2) == 0);
      step(rst, cs, wn, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
